// File: rtl/bus_sync_rx_pkg.sv
// Purpose: shared constants for the toggle-request CDC receive path.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
package bus_sync_rx_pkg;

    localparam int DEF_NUM_STAGES  = 2;
    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;
    localparam int XFER_COUNT_W    = 8;

    // Depths below two give no MTBF margin; above four only adds latency.
    function automatic bit sync_depth_ok(input int depth);
        return (depth >= MIN_SYNC_STAGES) && (depth <= MAX_SYNC_STAGES);
    endfunction

endpackage

// File: rtl/multi_flop_sync.sv
// Purpose: single-bit level synchronizer, NUM_STAGES-deep flop chain, resets to 0.
// Latency: async_in visible on sync_out NUM_STAGES rising edges after capture.
// Backpressure: none; a level crossing, it always follows its input.
// Ports: clk, rst (sync active-high), async_in (foreign-domain level), sync_out.
module multi_flop_sync
    import bus_sync_rx_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    // Pure flop-to-flop chain: any logic between stages would eat into the
    // resolution time the extra stages exist to provide.
    logic [NUM_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/bus_sync_rx.sv
// Purpose: destination end of the toggle-request bus handshake; captures a word per REQ toggle.
// Latency: SYNC_BUS/ENABLE_PULSE/ACK_TOGGLE update NUM_STAGES+1 edges after REQ_TOGGLE is first sampled.
// Backpressure: none locally; the source is throttled by waiting for ACK_TOGGLE to match REQ_TOGGLE.
// Ports: CLK, RST (sync active-high); UNSYNC_BUS + REQ_TOGGLE from the source domain;
//        SYNC_BUS (captured word), ENABLE_PULSE (1-cycle strobe), ACK_TOGGLE (to source),
//        XFER_COUNT (accepted transfers, wraps).
module bus_sync_rx
    import bus_sync_rx_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int BUS_WIDTH  = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [BUS_WIDTH-1:0]    UNSYNC_BUS,
    input  logic                    REQ_TOGGLE,
    output logic [BUS_WIDTH-1:0]    SYNC_BUS,
    output logic                    ENABLE_PULSE,
    output logic                    ACK_TOGGLE,
    output logic [XFER_COUNT_W-1:0] XFER_COUNT
);

    if (!sync_depth_ok(NUM_STAGES)) begin : g_bad_depth
        $error("bus_sync_rx: NUM_STAGES=%0d outside %0d..%0d",
               NUM_STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES);
    end
    if (BUS_WIDTH < 1) begin : g_bad_width
        $error("bus_sync_rx: BUS_WIDTH=%0d must be at least 1", BUS_WIDTH);
    end

    logic req_s;
    logic req_d;
    logic req_edge;

    multi_flop_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_req_sync (
        .clk      (CLK),
        .rst      (RST),
        .async_in (REQ_TOGGLE),
        .sync_out (req_s)
    );

    // Either polarity of the synchronized toggle is one new word.
    assign req_edge = req_s ^ req_d;

    // UNSYNC_BUS is sampled only on the edge cycle: the source has held it
    // stable since before it toggled REQ, so no per-bit synchronization.
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_d        <= 1'b0;
            SYNC_BUS     <= '0;
            ENABLE_PULSE <= 1'b0;
            ACK_TOGGLE   <= 1'b0;
            XFER_COUNT   <= '0;
        end else begin
            req_d        <= req_s;
            ENABLE_PULSE <= req_edge;
            if (req_edge) begin
                SYNC_BUS   <= UNSYNC_BUS;
                ACK_TOGGLE <= ~ACK_TOGGLE;
                XFER_COUNT <= XFER_COUNT + XFER_COUNT_W'(1);
            end
        end
    end

endmodule
